// File: rtl/bht_update_ctrl_pkg.sv
// Shared CPU defines for the branch history table: index width, entry layout
// and the update controller's FSM state type.
package bht_update_ctrl_pkg;

    localparam int unsigned SIZE_OF_INDEX = 6;
    localparam int unsigned BHT_TAG_W     = 8;
    localparam int unsigned BHT_TARGET_W  = 32;

    typedef enum logic [1:0] {
        CntSnt = 2'd0,
        CntWnt = 2'd1,
        CntWt  = 2'd2,
        CntSt  = 2'd3
    } bht_count_e;

    typedef enum logic [1:0] {
        BrCond = 2'd0,
        BrJump = 2'd1,
        BrCall = 2'd2,
        BrRet  = 2'd3
    } bht_type_e;

    typedef struct packed {
        logic [BHT_TAG_W-1:0]    tag;
        logic [BHT_TARGET_W-1:0] target;
        bht_type_e               br_type;
        bht_count_e              count;
    } BHT_Entry;

    typedef enum logic {
        StSweep = 1'b0,
        StIdle  = 1'b1
    } bht_upd_state_e;

endpackage

// File: rtl/bht_upd_queue.sv
// Coalescing FIFO of pending BHT writes: at most one entry per set index,
// with a combinational lookup port for read bypass.
module bht_upd_queue
    import bht_update_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned INDEX_W = SIZE_OF_INDEX
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enq,
    input  logic [INDEX_W-1:0]         enq_index,
    input  BHT_Entry                   enq_data,
    input  logic                       deq,
    input  logic                       flush,
    input  logic [INDEX_W-1:0]         rd_index,
    output logic                       rd_hit,
    output BHT_Entry                   rd_data,
    output logic                       head_valid,
    output logic [INDEX_W-1:0]         head_index,
    output BHT_Entry                   head_data,
    output logic                       full,
    output logic                       coal_ok,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DEPTH-1:0]   vld_q;
    logic [INDEX_W-1:0] idx_q  [DEPTH];
    BHT_Entry           data_q [DEPTH];
    logic [PTR_W-1:0]   head_q, tail_q;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [DEPTH-1:0]   match_vec;
    logic [PTR_W-1:0]   coal_slot;
    logic               coalesce, append;

    always_comb begin
        match_vec = '0;
        coal_slot = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (idx_q[i] == enq_index)) begin
                match_vec[i] = 1'b1;
                coal_slot    = PTR_W'(i);
            end
        end
    end

    // A head match is only reused while the head stays; once it leaves, re-enqueue.
    assign coalesce = enq && (|match_vec) && !(match_vec[head_q] && deq);
    assign append   = enq && !coalesce;
    assign coal_ok  = (|match_vec) && !match_vec[head_q];

    always_comb begin
        count_d = count_q;
        if (append && !deq) begin
            count_d = count_q + 1'b1;
        end else if (deq && !append) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                idx_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else if (flush) begin
            vld_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (deq) begin
                vld_q[head_q] <= 1'b0;
                head_q        <= head_q + 1'b1;
            end
            if (coalesce) begin
                data_q[coal_slot] <= enq_data;
            end
            // Written after the dequeue so a full-queue swap leaves the slot valid.
            if (append) begin
                vld_q[tail_q]  <= 1'b1;
                idx_q[tail_q]  <= enq_index;
                data_q[tail_q] <= enq_data;
                tail_q         <= tail_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    always_comb begin
        rd_hit  = 1'b0;
        rd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (idx_q[i] == rd_index)) begin
                rd_hit  = 1'b1;
                rd_data = data_q[i];
            end
        end
    end

    assign head_valid = vld_q[head_q];
    assign head_index = idx_q[head_q];
    assign head_data  = data_q[head_q];
    assign full       = (count_q == CNT_W'(DEPTH));
    assign count      = count_q;

endmodule

// File: rtl/bht_update_ctrl.sv
// BHT write-port controller: clears the table by sweeping after reset or on
// invalidate, otherwise drains a coalescing queue of branch-resolution updates.
module bht_update_ctrl
    import bht_update_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned INDEX_W = SIZE_OF_INDEX
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   Upd_Valid,
    input  logic [INDEX_W-1:0]     Upd_Index,
    input  BHT_Entry               Upd_Data,
    output logic                   Upd_Ready,
    input  logic                   Inv_Req,
    output logic                   Inv_Busy,
    input  logic                   BHT_Gnt,
    output logic                   BHT_We,
    output logic [INDEX_W-1:0]     BHT_Addr,
    output BHT_Entry               BHT_Din,
    input  logic [INDEX_W-1:0]     Rd_Index,
    output logic                   Byp_Hit,
    output BHT_Entry               Byp_Data,
    output logic [$clog2(DEPTH):0] Pend_Count
);

    bht_upd_state_e     state_q, state_d;
    logic [INDEX_W-1:0] cnt_q, cnt_d;

    logic               q_enq, q_deq;
    logic               q_head_valid, q_full, q_coal_ok;
    logic [INDEX_W-1:0] q_head_index;
    BHT_Entry           q_head_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StSweep;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StSweep: begin
                if (Inv_Req) begin
                    cnt_d = '0;
                end else if (BHT_Gnt) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        state_d = StIdle;
                    end
                end
            end
            StIdle: begin
                if (Inv_Req) begin
                    state_d = StSweep;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    always_comb begin
        BHT_We    = 1'b0;
        BHT_Addr  = q_head_index;
        BHT_Din   = q_head_data;
        Upd_Ready = 1'b0;
        Inv_Busy  = 1'b1;
        q_deq     = 1'b0;
        unique case (state_q)
            StSweep: begin
                // State already reads StSweep during reset; keep the port quiet until release.
                BHT_We   = !rst;
                BHT_Addr = cnt_q;
                BHT_Din  = '0;
            end
            StIdle: begin
                Inv_Busy  = 1'b0;
                BHT_We    = q_head_valid;
                q_deq     = q_head_valid && BHT_Gnt;
                Upd_Ready = !Inv_Req && (!q_full || q_deq || q_coal_ok);
            end
        endcase
    end

    assign q_enq = Upd_Valid && Upd_Ready;

    bht_upd_queue #(
        .DEPTH   (DEPTH),
        .INDEX_W (INDEX_W)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .enq        (q_enq),
        .enq_index  (Upd_Index),
        .enq_data   (Upd_Data),
        .deq        (q_deq),
        .flush      (Inv_Req),
        .rd_index   (Rd_Index),
        .rd_hit     (Byp_Hit),
        .rd_data    (Byp_Data),
        .head_valid (q_head_valid),
        .head_index (q_head_index),
        .head_data  (q_head_data),
        .full       (q_full),
        .coal_ok    (q_coal_ok),
        .count      (Pend_Count)
    );

endmodule

// File: doc/bht_update_ctrl.md
BHT_UPDATE_CTRL -- requirements
Module: bht_update_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4: update-queue entries (power of two, >=2).
REQ-002 SHALL have parameter INDEX_W, default `SIZE_OF_INDEX: BHT set-index width.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port Upd_Valid  in  1  branch-resolution BHT update offered by EXE.
REQ-006 SHALL have port Upd_Index  in  INDEX_W  target set of the update.
REQ-007 SHALL have port Upd_Data  in  $bits(BHT_Entry)  new entry (Tag, Target, Type, Count).
REQ-008 SHALL have port Upd_Ready  out  1  update accepted this cycle when high with Upd_Valid.
REQ-009 SHALL have port Inv_Req  in  1  single-cycle request to invalidate the whole BHT.
REQ-010 SHALL have port Inv_Busy  out  1  invalidation sweep in progress.
REQ-011 SHALL have port BHT_Gnt  in  1  BHT write port granted this cycle.
REQ-012 SHALL have port BHT_We / BHT_Addr / BHT_Din  out  1 / INDEX_W / $bits(BHT_Entry)  BHT write port.
REQ-013 SHALL have port Rd_Index  in  INDEX_W  index currently looked up by PREIF.
REQ-014 SHALL have port Byp_Hit / Byp_Data  out  1 / $bits(BHT_Entry)  queued pending entry for Rd_Index.
REQ-015 SHALL have port Pend_Count  out  $clog2(DEPTH)+1  number of valid queue entries.

Function
REQ-016 SHALL implement FSM states SWEEP and IDLE.
REQ-017 SWEEP SHALL drive BHT_We=1, BHT_Addr=sweep counter, BHT_Din='0; counter advances only on BHT_Gnt.
REQ-018 SWEEP SHALL go to IDLE on the cycle after counter = 2^INDEX_W-1 is written with BHT_Gnt=1; counter wraps to 0.
REQ-019 In SWEEP, Upd_Ready SHALL be 0; offered updates are dropped (EXE never stalls), Inv_Busy=1.
REQ-020 Inv_Req in IDLE SHALL enter SWEEP next cycle with counter 0 and empty the queue; an update offered the same cycle is dropped.
REQ-021 Inv_Req during SWEEP SHALL restart the counter at 0 next cycle.
REQ-022 In IDLE with queue non-empty, BHT_We SHALL be 1 with head entry on BHT_Addr/BHT_Din; head dequeues when BHT_Gnt=1, is held otherwise.
REQ-023 An update accepted in cycle t SHALL reach BHT_We no earlier than cycle t+1.
REQ-024 An update whose Upd_Index matches a valid non-head queue entry SHALL overwrite that entry in place (coalesce, no new entry); a match on the head while the head dequeues SHALL enqueue as new.
REQ-025 Upd_Ready in IDLE SHALL be 1 when not full, or full and head dequeues this cycle, or coalescing into a non-head entry.
REQ-026 Queue order SHALL be FIFO; at most one valid entry per index at any time.
REQ-027 Byp_Hit SHALL be combinational: 1 iff a valid queue entry holds Rd_Index; Byp_Data is that entry, '0 otherwise.
REQ-028 Pend_Count SHALL reflect registered queue occupancy (0..DEPTH).

Reset
REQ-029 While rst=1: state=SWEEP, counter=0, queue empty, BHT_We=0, Upd_Ready=0, Byp_Hit=0, Pend_Count=0, Inv_Busy=1.
REQ-030 After rst deasserts, the full sweep SHALL run before any update is accepted; rst mid-sweep or mid-drain restarts from REQ-029.

Structure
REQ-031 BHT_Entry typedef and SIZE_OF_INDEX SHALL come from the shared CPU defines package; no local redefinition.
REQ-032 The coalescing FIFO SHALL be sub-module bht_upd_queue (enqueue, coalesce, dequeue, flush, lookup ports).

Verification (INDEX_W=4, DEPTH=4)
REQ-033 Release rst, BHT_Gnt=1 -> 16 writes of '0 at addr 0..15, cycles 1..16; Inv_Busy falls, Upd_Ready=1 at cycle 17.
REQ-034 IDLE, BHT_Gnt=0, 5 updates to idx 1,2,3,4,5 -> first four accepted, Pend_Count=4, fifth Upd_Ready=0; BHT_Gnt=1 -> writes 1,2,3,4 in order.
REQ-035 BHT_Gnt=0, updates idx 7 (Count=WT) then idx 9 then idx 9 (Count=T) -> Pend_Count=2; Rd_Index=9 gives Byp_Hit=1, Count=T.
REQ-036 Queue holding 3 entries, Inv_Req=1 with Upd_Valid=1 -> Pend_Count=0 next cycle, SWEEP restarts at addr 0, update never written.
REQ-037 SWEEP at counter 10, BHT_Gnt toggling 1/0, Inv_Req pulse -> counter returns to 0, no address skipped afterward.
REQ-038 rst asserted mid-drain -> BHT_We=0 immediately (asynchronous), queue empty, sweep restarts from 0 on release.
